// File: rtl/poly_sq_pack_if.sv
// poly_sq_pack_if -- handshake bundle between the S_q multiplier output
// stream and the wide packed-polynomial consumer.
//   start     : begin a new polynomial (single-cycle pulse)
//   in_valid  : in_data carries a coefficient
//   in_data   : W-bit coefficient, unsigned mod 2^W
//   in_ready  : block accepts a coefficient this cycle
//   out_poly  : packed polynomial, coefficient i at [W*i+W : W*i+1]
//   out_valid : out_poly complete and stable
//   out_ack   : consumer has taken out_poly
//   err       : sticky dropped-coefficient flag (only with POLY_SQ_PACK_ERR_EN)
// slave is the deserializer side, master the producer/consumer side.
`timescale 1ns/1ps
interface poly_sq_pack_if #(
  parameter int N = 701,
  parameter int W = 13
);
  logic         start;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [N*W:1] out_poly;
  logic         out_valid;
  logic         out_ack;
`ifdef POLY_SQ_PACK_ERR_EN
  logic         err;

  modport slave  (input  start, in_valid, in_data, out_ack,
                  output in_ready, out_poly, out_valid, err);
  modport master (output start, in_valid, in_data, out_ack,
                  input  in_ready, out_poly, out_valid, err);
`else
  modport slave  (input  start, in_valid, in_data, out_ack,
                  output in_ready, out_poly, out_valid);
  modport master (output start, in_valid, in_data, out_ack,
                  input  in_ready, out_poly, out_valid);
`endif
endinterface

// File: rtl/poly_sq_pack.sv
// poly_sq_pack -- deserializer assembling N W-bit coefficients, one per
// handshake, into the N*W-bit packed polynomial vector. Coefficient 0
// arrives first and ends up in the least-significant field [W:1].
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : poly_sq_pack_if.slave (start/in_valid/in_data/in_ready,
//          out_poly/out_valid/out_ack, and err when enabled)
// Optional feature: define POLY_SQ_PACK_ERR_EN to add the sticky err
// output flagging in_valid seen while not filling.
`timescale 1ns/1ps
module poly_sq_pack #(
  parameter int N = 701,
  parameter int W = 13
) (
  input  logic          clk,
  input  logic          rst,
  poly_sq_pack_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic [N*W:1]   poly_r;
  logic           in_ready_r;
  logic           out_valid_r;
`ifdef POLY_SQ_PACK_ERR_EN
  logic           err_r;

  assign bus.err = err_r;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_poly  = poly_r;

  // Control FSM, fill counter and shift register; handshake outputs are
  // registered alongside the next state so they depend on state only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      poly_r      <= {(N*W){1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef POLY_SQ_PACK_ERR_EN
      err_r       <= 1'b0;
`endif
    end else if (bus.start) begin
      // start overrides any coincident beat, ack or violation.
      state_r     <= FILL;
      cnt_r       <= {CW{1'b0}};
      poly_r      <= {(N*W){1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef POLY_SQ_PACK_ERR_EN
      err_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
`ifdef POLY_SQ_PACK_ERR_EN
          if (bus.in_valid) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
`endif
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
        FILL: begin
          // in_ready is high throughout FILL, so in_valid alone is an accept.
          if (bus.in_valid) begin
            // Newest coefficient enters at the top; after N beats the
            // first one has walked down to [W:1].
            poly_r <= {bus.in_data, poly_r[N*W:W+1]};
            cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CW'(N - 1)) begin
              state_r     <= FULL;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
            end
          end else begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
`ifdef POLY_SQ_PACK_ERR_EN
          if (bus.in_valid) begin
            err_r <= 1'b1;
          end else begin
            err_r <= err_r;
          end
`endif
          in_ready_r <= 1'b0;
          // The vector is retained on the way back to IDLE.
          if (bus.out_ack) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CW{1'b0}};
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sq_pack.sv
// tb_poly_sq_pack -- directed self-checking bench for poly_sq_pack.
// A coefficient-level model (list of accepted coefficients plus a phase)
// predicts in_ready/out_valid/out_poly (and err with POLY_SQ_PACK_ERR_EN),
// checked every negative edge; literal checks pin the model.
`timescale 1ns/1ps
module tb_poly_sq_pack;

  localparam int N = 701;
  localparam int W = 13;

  logic clk;
  logic rst;

  poly_sq_pack_if #(.N(N), .W(W)) b ();

  poly_sq_pack #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int nvec = 0;
  int nerr = 0;

  // Model: phase 0 idle, 1 filling, 2 full; mk coefficients accepted so far.
  int          mph = 0;
  int          mk  = 0;
  logic [W-1:0] mcoef [0:N-1];
  bit          merr = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each active edge or asynchronous reset.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mph = 0; mk = 0; merr = 1'b0;
      end else if (b.start) begin
        mph = 1; mk = 0; merr = 1'b0;
      end else if (mph == 1) begin
        if (b.in_valid) begin
          mcoef[mk] = b.in_data;
          mk++;
          if (mk == N) mph = 2;
        end
      end else begin
        if (b.in_valid) merr = 1'b1;
        if (mph == 2 && b.out_ack) mph = 0;
      end
    end
  end

  // Compare process: every negative edge, DUT against model.
  initial begin
    forever begin
      @(negedge clk);
      nvec++;
      if (b.in_ready !== (mph == 1) || b.out_valid !== (mph == 2)) begin
        nerr++;
        $display("FAIL handshake: got ready=%b valid=%b expected ready=%b valid=%b at %0t",
                 b.in_ready, b.out_valid, (mph == 1), (mph == 2), $time);
      end
      nvec++;
      begin
        int bad;
        logic [W-1:0] e;
        logic [W-1:0] a;
        bad = -1;
        e = '0;
        a = '0;
        for (int f = 0; f < N; f++) begin
          e = (f >= N - mk) ? mcoef[f - (N - mk)] : 13'd0;
          a = b.out_poly[W*f+1 +: W];
          if (a !== e) begin
            bad = f;
            break;
          end
        end
        if (bad >= 0) begin
          nerr++;
          $display("FAIL out_poly: field %0d got %0h expected %0h at %0t", bad, a, e, $time);
        end
      end
`ifdef POLY_SQ_PACK_ERR_EN
      nvec++;
      if (b.err !== merr) begin
        nerr++;
        $display("FAIL err: got %b expected %b at %0t", b.err, merr, $time);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
  endtask

  task automatic pulse_ack();
    b.out_ack = 1'b1;
    tick();
    b.out_ack = 1'b0;
  endtask

  // Feed n coefficients (ramp i mod 8192 or constant 0x0AAA), optionally
  // with in_valid low every third cycle; returns cycles spent.
  task automatic feed(input int n, input bit bubble, input bit konst, output int cycles);
    int acc;
    int cyc;
    bit iv;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 3 * n + 10) begin
      iv = !(bubble && (cyc % 3 == 2));
      b.in_valid = iv;
      b.in_data  = konst ? 13'h0AAA : 13'(acc % 8192);
      tick();
      cyc++;
      if (iv) acc++;
    end
    b.in_valid = 1'b0;
    b.in_data  = 13'h0000;
    cycles = cyc;
    if (acc < n) chk("feed_timeout", 32'(acc), 32'(n));
  endtask

  initial begin
    int cyc;
    rst        = 1'b1;
    b.start    = 1'b0;
    b.in_valid = 1'b0;
    b.in_data  = 13'h0000;
    b.out_ack  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("reset_valid", 32'(b.out_valid), 32'd0);
    chk("reset_ready", 32'(b.in_ready), 32'd0);
    chk("reset_poly_zero", 32'(b.out_poly == '0), 32'd1);

    // in_valid in IDLE is ignored (flagged with err when enabled).
    b.in_valid = 1'b1;
    b.in_data  = 13'h1234;
    repeat (3) tick();
    b.in_valid = 1'b0;
    chk("idle_ready", 32'(b.in_ready), 32'd0);
    chk("idle_valid", 32'(b.out_valid), 32'd0);
`ifdef POLY_SQ_PACK_ERR_EN
    chk("idle_err", 32'(b.err), 32'd1);
`endif

    // Ramp fill, continuous.
    pulse_start();
`ifdef POLY_SQ_PACK_ERR_EN
    chk("start_clears_err", 32'(b.err), 32'd0);
`endif
    chk("fill_ready", 32'(b.in_ready), 32'd1);
    feed(N, 1'b0, 1'b0, cyc);
    chk("ramp_latency", 32'(cyc), 32'd701);
    chk("ramp_valid", 32'(b.out_valid), 32'd1);
    chk("ramp_f0", 32'(b.out_poly[13:1]), 32'd0);
    chk("ramp_f1", 32'(b.out_poly[26:14]), 32'd1);
    chk("ramp_f700", 32'(b.out_poly[9113:9101]), 32'd700);

    // Hold in FULL without ack, then ack.
    repeat (50) tick();
    chk("hold_ready", 32'(b.in_ready), 32'd0);
    chk("hold_f700", 32'(b.out_poly[9113:9101]), 32'd700);
    pulse_ack();
    chk("ack_valid", 32'(b.out_valid), 32'd0);
    chk("ack_retain_f700", 32'(b.out_poly[9113:9101]), 32'd700);

    // Bubbled ramp fill.
    pulse_start();
    feed(N, 1'b1, 1'b0, cyc);
    chk("bubble_valid", 32'(b.out_valid), 32'd1);
    chk("bubble_f1", 32'(b.out_poly[26:14]), 32'd1);
    chk("bubble_f350", 32'(b.out_poly[4563:4551]), 32'd350);
    pulse_ack();

    // Restart mid-fill with a coincident beat.
    pulse_start();
    feed(300, 1'b0, 1'b0, cyc);
    b.start    = 1'b1;
    b.in_valid = 1'b1;
    b.in_data  = 13'h1FFF;
    tick();
    b.start    = 1'b0;
    b.in_valid = 1'b0;
    chk("restart_poly_zero", 32'(b.out_poly == '0), 32'd1);
    chk("restart_ready", 32'(b.in_ready), 32'd1);
    feed(N, 1'b0, 1'b1, cyc);
    chk("const_valid", 32'(b.out_valid), 32'd1);
    chk("const_f0", 32'(b.out_poly[13:1]), 32'h0AAA);
    chk("const_f700", 32'(b.out_poly[9113:9101]), 32'h0AAA);
    // start coinciding with ack in FULL goes to FILL.
    b.out_ack = 1'b1;
    pulse_start();
    b.out_ack = 1'b0;
    chk("start_ack_ready", 32'(b.in_ready), 32'd1);

    // Asynchronous reset mid-fill.
    feed(400, 1'b0, 1'b0, cyc);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_poly_zero", 32'(b.out_poly == '0), 32'd1);
    chk("async_rst_ready", 32'(b.in_ready), 32'd0);
    chk("async_rst_valid", 32'(b.out_valid), 32'd0);
    #3;
    rst = 1'b0;
    tick();
    pulse_start();
    feed(N, 1'b0, 1'b0, cyc);
    chk("post_rst_latency", 32'(cyc), 32'd701);
    chk("post_rst_valid", 32'(b.out_valid), 32'd1);
    chk("post_rst_f700", 32'(b.out_poly[9113:9101]), 32'd700);
    pulse_ack();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
